// File: rtl/sgd_pkg.sv
// sgd_pkg: shared states, constants and helpers for the SGD engine blocks
`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 8
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 12
`endif
`ifndef BIT_WIDTH_OF_BANK
`define BIT_WIDTH_OF_BANK 5
`endif
`ifndef ENGINE_NUM_WIDTH
`define ENGINE_NUM_WIDTH 3
`endif
package sgd_pkg;
  localparam int NW_SHIFT = `BIT_WIDTH_OF_BANK + `ENGINE_NUM_WIDTH;
  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, WAIT_LOW} wb_state_e;
  function automatic logic [11:0] calc_num_words(input logic [31:0] dimension);
    return 12'(dimension >> NW_SHIFT) + 12'(|dimension[NW_SHIFT-1:0]);
  endfunction
endpackage

// File: rtl/sgd_wb_fifo.sv
// sgd_wb_fifo: synchronous beat buffer with occupancy count
module sgd_wb_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/sgd_x_host_wb.sv
// sgd_x_host_wb: streams the model BRAM back to host memory as burst write commands
`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 8
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 12
`endif
module sgd_x_host_wb import sgd_pkg::*; #(
  parameter int DATA_W = `NUM_BITS_PER_BANK * 32,
  parameter int ADDR_W = `DIS_X_BIT_DEPTH,
  parameter int RD_LAT = 2,
  parameter int MAX_BURST = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writing_x_to_host_memory_en,
  output logic              writing_x_to_host_memory_done,
  input  logic [31:0]       dimension,
  input  logic [63:0]       x_host_base_addr,
  output logic              x_rd_en,
  output logic [ADDR_W-1:0] x_rd_addr,
  input  logic [DATA_W-1:0] x_rd_data,
  output logic              wb_cmd_valid,
  input  logic              wb_cmd_ready,
  output logic [63:0]       wb_cmd_addr,
  output logic [7:0]        wb_cmd_len,
  output logic              wb_data_valid,
  input  logic              wb_data_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_data_last,
  output logic              wb_busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  wb_state_e state, nxt;
  logic en_q, en_qq, start, push, pop, last_pop, more;
  logic [11:0] num_words, word_idx, rem;
  logic [7:0] burst_len, issued, sent;
  logic [RD_LAT-1:0] vld;
  logic [CW-1:0] in_flight, fifo_cnt;
  logic [DATA_W-1:0] fifo_dout;
  assign start = state == IDLE && en_q && !en_qq;
  assign rem = num_words - word_idx;
  assign push = vld[RD_LAT-1];
  assign wb_cmd_valid = state == CMD;
  assign wb_cmd_len = wb_cmd_valid ? (rem > 12'(MAX_BURST) ? 8'(MAX_BURST) : rem[7:0]) : '0;
  assign wb_cmd_addr = wb_cmd_valid ? x_host_base_addr + 64'(word_idx) * 64'(DATA_W / 8) : '0;
  // Reads in flight plus buffered beats never exceed the buffer, so no push can be lost
  assign x_rd_en = state == DATA && issued < burst_len && 32'(in_flight) + 32'(fifo_cnt) < FIFO_DEPTH;
  assign x_rd_addr = ADDR_W'(word_idx + 12'(issued));
  assign wb_data_valid = state == DATA && fifo_cnt != '0;
  assign wb_data = wb_data_valid ? fifo_dout : '0;
  assign wb_data_last = wb_data_valid && sent == burst_len - 8'd1;
  assign pop = wb_data_valid && wb_data_ready;
  assign last_pop = pop && wb_data_last;
  assign more = word_idx + 12'(burst_len) < num_words;
  assign writing_x_to_host_memory_done = state == DONE;
  assign wb_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = start ? (calc_num_words(dimension) != '0 ? CMD : DONE) : IDLE;
      CMD:      nxt = wb_cmd_ready ? DATA : CMD;
      DATA:     nxt = last_pop ? (more ? CMD : DONE) : DATA;
      DONE:     nxt = WAIT_LOW;
      WAIT_LOW: nxt = writing_x_to_host_memory_en ? WAIT_LOW : IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // Edge detector resets high so a level held across reset is not taken as a new request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en_q <= 1'b1;
      en_qq <= 1'b1;
      num_words <= '0;
      word_idx <= '0;
      burst_len <= '0;
      issued <= '0;
      sent <= '0;
      vld <= '0;
      in_flight <= '0;
    end else begin
      en_q <= writing_x_to_host_memory_en;
      en_qq <= en_q;
      vld <= RD_LAT'({vld, x_rd_en});
      in_flight <= in_flight + CW'(x_rd_en) - CW'(push);
      if (start) begin
        num_words <= calc_num_words(dimension);
        word_idx <= '0;
      end
      if (wb_cmd_valid && wb_cmd_ready) begin
        burst_len <= wb_cmd_len;
        issued <= '0;
        sent <= '0;
      end
      if (x_rd_en) issued <= issued + 8'd1;
      if (pop) sent <= sent + 8'd1;
      if (last_pop) word_idx <= word_idx + 12'(burst_len);
    end
  sgd_wb_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(x_rd_data),
    .pop(pop), .dout(fifo_dout), .count(fifo_cnt)
  );
endmodule

// File: doc/sgd_x_host_wb.md
SGD_X_HOST_WB -- requirements
Module: sgd_x_host_wb

Interface
REQ-001 SHALL have parameters: DATA_W, default `NUM_BITS_PER_BANK*32, BRAM word and host beat width; ADDR_W, default `DIS_X_BIT_DEPTH, model BRAM address width; RD_LAT, default 2, BRAM read latency in cycles; MAX_BURST, default 64, maximum beats per host write command; FIFO_DEPTH, default 8, beat buffer depth.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; everything is posedge clk.
- rst  in  1  asynchronous, active-high reset.
- writing_x_to_host_memory_en  in  1  level request to write back the model.
- writing_x_to_host_memory_done  out  1  one-cycle completion pulse.
- dimension  in  32  feature count.
- x_host_base_addr  in  64  host byte address of the model buffer.
- x_rd_en  out  1  model BRAM read strobe.
- x_rd_addr  out  ADDR_W  model BRAM word address.
- x_rd_data  in  DATA_W  read data, valid RD_LAT cycles after x_rd_en.
- wb_cmd_valid  out  1  host write command valid.
- wb_cmd_ready  in  1  host write command ready.
- wb_cmd_addr  out  64  command byte address.
- wb_cmd_len  out  8  command beat count, 1..MAX_BURST.
- wb_data_valid  out  1  write beat valid.
- wb_data_ready  in  1  write beat ready.
- wb_data  out  DATA_W  write beat payload.
- wb_data_last  out  1  last beat of the command.
- wb_busy  out  1  high in every state except IDLE.

Function
REQ-003 SHALL register num_words = dimension[31:`BIT_WIDTH_OF_BANK+`ENGINE_NUM_WIDTH] + (low bits != 0), truncated to 12 bits, on the start event.
REQ-004 SHALL define the start event as a rising edge of writing_x_to_host_memory_en, sampled while in IDLE; a level that stays high SHALL NOT retrigger.
REQ-005 SHALL implement states IDLE, CMD, DATA, DONE and WAIT_LOW.
REQ-006 On start, IDLE SHALL go to CMD if num_words != 0, and to DONE if num_words == 0.
REQ-007 CMD SHALL hold wb_cmd_valid with wb_cmd_addr = x_host_base_addr + word_idx*(DATA_W/8) and wb_cmd_len = min(MAX_BURST, num_words - word_idx); on handshake it SHALL go to DATA.
REQ-008 In DATA, x_rd_en SHALL be asserted only while beats issued for the burst < wb_cmd_len and (reads in flight + FIFO occupancy) < FIFO_DEPTH; x_rd_addr SHALL equal word_idx of the issued word, starting at 0.
REQ-009 x_rd_data SHALL be pushed into the FIFO exactly RD_LAT cycles after each x_rd_en, using a valid shift pipeline; no beat SHALL ever be dropped.
REQ-010 The FIFO head SHALL drive wb_data / wb_data_valid; wb_data_last SHALL be 1 on the wb_cmd_len-th beat of the burst; payload SHALL be held stable while valid && !ready.
REQ-011 When the last beat of a burst is accepted, DATA SHALL go to CMD if accepted words < num_words, else to DONE.
REQ-012 DONE SHALL assert writing_x_to_host_memory_done for exactly one cycle, then go to WAIT_LOW.
REQ-013 WAIT_LOW SHALL return to IDLE when writing_x_to_host_memory_en == 0.
REQ-014 Deassertion of writing_x_to_host_memory_en during CMD or DATA SHALL be ignored; the write-back SHALL complete.
REQ-015 The command and its first beat SHALL NOT be presented in the same cycle; a command SHALL be accepted before any of its beats.
REQ-016 word_idx SHALL be 12 bits; address arithmetic SHALL be 64-bit with no wrap.

Reset
REQ-017 rst SHALL force state IDLE, clear all counters, the FIFO and the read pipeline, and drive every output to 0, including wb_cmd_addr and wb_data.
REQ-018 rst asserted mid-burst SHALL discard in-flight reads; after rst, no done pulse SHALL occur without a new rising edge of writing_x_to_host_memory_en.

Structure
REQ-019 The state enumeration and the num_words shift constant (`BIT_WIDTH_OF_BANK+`ENGINE_NUM_WIDTH) SHALL live in the shared package sgd_pkg.
REQ-020 The beat buffer SHALL be one sub-module, sgd_wb_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, with count output).

Verification
REQ-021 dimension=1024 (num_words=4), ready always 1 -> one command (len=4, addr=base), 4 beats, last on beat 4, done pulse 1 cycle.
REQ-022 num_words=130, MAX_BURST=64 -> three commands with len 64/64/2 at addr base, base+64*DATA_W/8, base+128*DATA_W/8; 130 beats, one done.
REQ-023 wb_data_ready toggling 1-in-3 with FIFO_DEPTH=8 -> in-flight reads + FIFO occupancy never exceeds 8; payload stable under stall; beat sequence matches BRAM contents.
REQ-024 en held high for 10 cycles after done -> no second command; after en low then high -> new full write-back.
REQ-025 dimension=0 -> no command, no x_rd_en, done 2 cycles after the rising edge of en.
REQ-026 rst pulsed during beat 20 of 64 -> all outputs 0 next cycle; restart produces a clean 64-beat burst from word 0.
